mux_rr_arbiter: RTL and testbench

//  Shares one N:1 data mux (one output channel) among N_REQ requesters using valid/ready handshakes.

---
 rtl/mux_rr_arbiter.sv | 116 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Shares one N_REQ:1 data mux (a single valid/ready output channel) among
//   N_REQ requesters. A round-robin arbiter registers the grant, holds it until
//   the granted requester transfers, then rotates priority past that requester.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous reset, active-high
//   req_valid  per-requester valid
//   req_data   requester i data in bits [i*W +: W]
//   req_ready  per-requester accept (only the granted bit can be high)
//   out_valid  output channel valid
//   out_data   output channel data (0 when idle)
//   out_ready  downstream accept
//   grant      one-hot current grant, all 0 when idle
//   busy       1 while a requester holds the grant
module mux_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  input  logic               out_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int          IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NU       = N_REQ;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [IW-1:0] grant_idx, grant_idx_n;
  logic [IW-1:0] last_idx, last_idx_n;

  // First valid requester searching last+1 .. last+N_REQ (mod N_REQ);
  // 'last' itself is visited last, so it only wins when it is the sole one.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                            input logic [IW-1:0]    last);
    logic [IW-1:0] sel;
    logic          found;
    int unsigned   j;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NU; k++) begin
      j = (32'(last) + k) % NU;
      if (!found && v[IW'(j)]) begin
        sel   = IW'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_idx  <= LAST_RST;
    end else begin
      state     <= state_n;
      grant_idx <= grant_idx_n;
      last_idx  <= last_idx_n;
    end
  end

  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    last_idx_n  = last_idx;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_n     = GRANT;
          grant_idx_n = rr_pick(req_valid, last_idx);
        end
      end
      GRANT: begin
        if (!req_valid[grant_idx]) begin
          // requester withdrew before acceptance: release, keep priority
          state_n = IDLE;
        end else if (out_ready) begin
          // transfer; the granted requester is itself valid, so a pick
          // always exists and the next grant follows with no bubble
          last_idx_n  = grant_idx;
          grant_idx_n = rr_pick(req_valid, grant_idx);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == GRANT);
    grant     = '0;
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    if (busy) begin
      grant[grant_idx]     = 1'b1;
      req_ready[grant_idx] = out_ready;
      out_valid            = req_valid[grant_idx];
      for (int unsigned i = 0; i < NU; i++) begin
        if (IW'(i) == grant_idx) out_data = req_data[i*W +: W];
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios followed by randomized
// traffic, with a scoreboard of expected transfers and per-cycle output checks.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .grant(grant), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // reference model: who owns the channel and whose turn was last
  bit           m_busy = 1'b0;
  int           m_g    = 0;
  int           m_last = N - 1;
  logic         p_rst  = 1'b1;
  logic         p_rdy  = 1'b0;
  logic [N-1:0] p_v    = '0;
  int           acc_idx = -1;

  logic [N-1:0] e_grant, e_rr;
  logic         e_ov, e_busy;
  logic [W-1:0] e_od;
  bit           chk_en = 1'b0;
  logic [15:0]  sb[$];

  function automatic int pick(input logic [N-1:0] v, input int after);
    for (int k = 1; k <= N; k++) if (v[(after + k) % N]) return (after + k) % N;
    return -1;
  endfunction

  function automatic logic [7:0] owner(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return 8'(i);
    return 8'hFF;
  endfunction

  // advance the model over the cycle that just ended
  task automatic model_update();
    acc_idx = -1;
    if (p_rst) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else if (!m_busy) begin
      if (p_v != '0) begin
        m_busy = 1'b1;
        m_g    = pick(p_v, m_last);
      end
    end else if (!p_v[m_g]) begin
      m_busy = 1'b0;
    end else if (p_rdy) begin
      acc_idx = m_g;
      m_last  = m_g;
      m_g     = pick(p_v, m_g);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] v, input logic rdy,
                      input logic [N*W-1:0] d);
    @(posedge clk);
    #2;
    model_update();
    rst = r; req_valid = v; out_ready = rdy; req_data = d;
    p_rst = r; p_v = v; p_rdy = rdy;
    e_busy = m_busy; e_grant = '0; e_rr = '0; e_ov = 1'b0; e_od = '0;
    if (m_busy) begin
      e_grant[m_g] = 1'b1;
      e_rr[m_g]    = rdy;
      e_ov         = v[m_g];
      e_od         = d[m_g*W +: W];
      if (v[m_g] && rdy) sb.push_back({8'(m_g), d[m_g*W +: W]});
    end
    chk_en = 1'b1;
  endtask

  task automatic expect_grant(input string name, input logic [N-1:0] g);
    #1;
    check(name, 64'(grant), 64'(g));
  endtask

  // monitor: mid-cycle output compare, and scoreboard pop on each transfer
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("outputs", 64'({grant, req_ready, out_valid, busy, out_data}),
                         64'({e_grant, e_rr, e_ov, e_busy, e_od}));
        if (out_valid && out_ready) begin
          check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
          if (sb.size() != 0) check("xfer", 64'({owner(grant), out_data}), 64'(sb.pop_front()));
        end
      end
    end
  end

  localparam logic [N*W-1:0] D = 32'h44A5_2211;

  logic [N-1:0]   rv;
  logic [N*W-1:0] rd;

  initial begin
    // reset held with all requesters valid, then fairness rotation
    step(1'b1, 4'b1111, 1'b1, D);
    step(1'b1, 4'b1111, 1'b1, D);
    expect_grant("rst_grant", 4'b0000);
    step(1'b0, 4'b1111, 1'b1, D);
    expect_grant("arb_latency", 4'b0000);
    step(1'b0, 4'b1111, 1'b1, D); expect_grant("rr0", 4'b0001);
    step(1'b0, 4'b1111, 1'b1, D); expect_grant("rr1", 4'b0010);
    step(1'b0, 4'b1111, 1'b1, D); expect_grant("rr2", 4'b0100);
    step(1'b0, 4'b1111, 1'b1, D); expect_grant("rr3", 4'b1000);
    step(1'b0, 4'b1111, 1'b1, D); expect_grant("rr_wrap", 4'b0001);

    // backpressure on req2, req1 rises meanwhile
    step(1'b1, 4'b0000, 1'b0, D);
    step(1'b0, 4'b0100, 1'b0, D);
    step(1'b0, 4'b0100, 1'b0, D);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0110, 1'b0, D);
      expect_grant("bp_hold", 4'b0100);
      check("bp_data", 64'(out_data), 64'(8'hA5));
    end
    step(1'b0, 4'b0110, 1'b1, D);
    step(1'b0, 4'b0010, 1'b0, D);
    expect_grant("bp_next", 4'b0010);

    // sole streamer req3, three back-to-back items
    step(1'b1, 4'b0000, 1'b0, D);
    step(1'b0, 4'b1000, 1'b1, D);
    step(1'b0, 4'b1000, 1'b1, 32'h0100_0000); expect_grant("solo1", 4'b1000);
    step(1'b0, 4'b1000, 1'b1, 32'h0200_0000); expect_grant("solo2", 4'b1000);
    step(1'b0, 4'b1000, 1'b1, 32'h0300_0000); expect_grant("solo3", 4'b1000);
    step(1'b0, 4'b0000, 1'b1, D);
    step(1'b0, 4'b0000, 1'b1, D);
    expect_grant("solo_idle", 4'b0000);

    // reset in the middle of a stalled grant
    step(1'b1, 4'b0000, 1'b0, D);
    step(1'b0, 4'b0010, 1'b0, D);
    step(1'b0, 4'b0010, 1'b0, D);
    expect_grant("pre_rst", 4'b0010);
    step(1'b1, 4'b0011, 1'b0, D);
    step(1'b0, 4'b0011, 1'b0, D);
    expect_grant("post_rst", 4'b0000);
    check("post_rst_busy", 64'(busy), 64'(0));
    step(1'b0, 4'b0011, 1'b1, D);
    expect_grant("post_rst_pri", 4'b0001);

    // granted requester withdraws before acceptance
    step(1'b1, 4'b0000, 1'b0, D);
    step(1'b0, 4'b0011, 1'b0, D);
    step(1'b0, 4'b0011, 1'b0, D);
    expect_grant("drop_pre", 4'b0001);
    step(1'b0, 4'b0010, 1'b0, D);
    step(1'b0, 4'b0010, 1'b0, D);
    expect_grant("drop_idle", 4'b0000);
    step(1'b0, 4'b0010, 1'b1, D);
    expect_grant("drop_next", 4'b0010);

    // randomized traffic: requesters hold valid/data until accepted,
    // with rare withdrawals and rare resets
    rv = '0;
    rd = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(rv[i] && acc_idx != i && $urandom_range(0, 31) != 0)) begin
          rv[i] = ($urandom_range(0, 2) != 0);
          rd[i*W +: W] = 8'($urandom);
        end
      end
      step(($urandom_range(0, 199) == 0), rv, ($urandom_range(0, 9) < 7), rd);
    end

    @(negedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
